watchdog_v2: RTL and testbench

- Parametrised next-generation system watchdog in the CPLD CSR space, 8-bit CSR bus.
- Counter width is configurable up to 16 bits.
- Adds a pretimeout interrupt, sticky write-1-to-clear status, and an optional window (early-kick) mode.
- Drives two bite outputs (reset/recovery lines) and a recovery-mode strap; counts on a shared clock-enable tick.

---
 rtl/watchdog_v2_pkg.sv | 33 +++
 rtl/watchdog_v2_counter.sv | 73 +++++++
 rtl/watchdog_v2.sv | 189 ++++++++++++++++++
 tb/tb_watchdog_v2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_v2_pkg.sv
// rtl/watchdog_v2_pkg.sv - shared constants for the watchdog_v2 CSR block
//
// Purpose: register offsets (relative to BASE_ADDR), CTRL/STATUS bit
// positions and the default kick byte, shared by the top and the counter.
// Ports: none (package).

package watchdog_v2_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [4:0] R_CTRL   = 5'd0;
  localparam logic [4:0] R_TOUT_L = 5'd1;
  localparam logic [4:0] R_TOUT_H = 5'd2;
  localparam logic [4:0] R_KICK   = 5'd3;
  localparam logic [4:0] R_CNT_L  = 5'd4;
  localparam logic [4:0] R_CNT_H  = 5'd5;
  localparam logic [4:0] R_PRETO  = 5'd6;
  localparam logic [4:0] R_STATUS = 5'd7;
  localparam logic [4:0] R_WIN    = 5'd8;

  // CTRL layout: {OE[1:0], 0, PTIE, 0, LOCK, EN[1:0]}
  localparam int unsigned CTRL_EN_LSB = 0;
  localparam int unsigned CTRL_LOCK   = 2;
  localparam int unsigned CTRL_PTIE   = 4;
  localparam int unsigned CTRL_OE_LSB = 6;

  // STATUS layout: {5'b0, EARLY, PRE, BITE}
  localparam int unsigned ST_BITE  = 0;
  localparam int unsigned ST_PRE   = 1;
  localparam int unsigned ST_EARLY = 2;

  localparam logic [7:0] KICK_VALUE_DEFAULT = 8'h6b;

endpackage

// File: rtl/watchdog_v2_counter.sv
// rtl/watchdog_v2_counter.sv - saturating watchdog down-counter with pretimeout match
//
// Purpose: the watchdog count register. Priority (highest first): reset
// reload (only when reload_on_rst_i), force to zero, load, ce decrement.
// The counter stops at zero and never wraps.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   reload_on_rst_i    reload RST_VALUE on reset; otherwise the count survives reset
//   force_zero_i       early kick: drive the count to zero
//   load_i/load_val_i  reload with the timeout value
//   dec_i              qualified count tick
//   preto_i            pretimeout compare value (0 disables)
//   cnt_o, zero_o      live count and its zero flag (bite)
//   pre_hit_o          this cycle's decrement lands on preto_i

module wdt_counter
  import watchdog_v2_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH = 12,
  parameter logic [CNT_WIDTH-1:0]  RST_VALUE = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reload_on_rst_i,
  input  logic                 force_zero_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  input  logic [7:0]           preto_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 zero_o,
  output logic                 pre_hit_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] preto_ext;
  logic                 dec_fire;

  assign preto_ext = CNT_WIDTH'(preto_i);

  always_comb begin
    cnt_d    = cnt_q;
    dec_fire = 1'b0;
    if (force_zero_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d    = cnt_q - 1'b1;
      dec_fire = 1'b1;
    end
  end

  // A pretimeout at or above the timeout can only be "reached" from a stale
  // count left over from before a TOUT rewrite, so it is masked explicitly.
  assign pre_hit_o = dec_fire && (preto_i != 8'h00) && (cnt_d == preto_ext) &&
                     (preto_ext < load_val_i);

  // Failsafe: when the owner has EN[1] set the count is kept across reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (reload_on_rst_i) begin
        cnt_q <= RST_VALUE;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/watchdog_v2.sv
// rtl/watchdog_v2.sv - system watchdog with pretimeout irq and optional window mode
//
// Purpose: CSR-mapped watchdog. Counts down on ce while EN!=0, bites at zero,
// raises a pretimeout event, keeps sticky W1C status and a one-cycle irq.
// Optional macro WATCHDOG_WINDOW_EN adds the WIN register and early-kick bite.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   ce                       count tick
//   csr_a/csr_di/csr_we      CSR address, write data, write strobe
//   csr_do                   combinational read data (0 when unmapped)
//   wdt_out                  bite outputs gated by CTRL.OE
//   force_recovery_mode      CTRL.EN[1]
//   irq                      one-cycle interrupt pulse

module watchdog_v2
  import watchdog_v2_pkg::*;
#(
  parameter logic [4:0]           BASE_ADDR       = 5'h0,
  parameter int unsigned          CNT_WIDTH       = 12,
  parameter logic [1:0]           DEFAULT_EN      = 2'b00,
  parameter logic [1:0]           DEFAULT_OE      = 2'b00,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_TIMEOUT = {CNT_WIDTH{1'b1}},
  parameter logic [7:0]           KICK_VALUE      = KICK_VALUE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  output logic [1:0] wdt_out,
  output logic       force_recovery_mode,
  output logic       irq
);

  logic [4:0]           off;
  logic [1:0]           en_q, en_d, oe_q, oe_d;
  logic                 ptie_q, ptie_d, lock_q, lock_d;
  logic [CNT_WIDTH-1:0] tout_q, tout_d;
  logic [7:0]           preto_q, preto_d;
  logic [2:0]           status_q, status_d, status_set, status_clr;
  logic                 prev_bite_q, irq_q, irq_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [15:0]          cnt16, tout16;
  logic                 bite, pre_hit, bite_edge;
  logic                 kick_valid, early_kick, kick_load;

  // Offsets wrap modulo 32, so a BASE_ADDR near the top still decodes.
  assign off    = csr_a - BASE_ADDR;
  assign cnt16  = 16'(cnt);
  assign tout16 = 16'(tout_q);

  assign kick_valid = csr_we && (off == R_KICK) && (csr_di == KICK_VALUE);

`ifdef WATCHDOG_WINDOW_EN
  logic [7:0] win_q, win_d;
  assign early_kick = kick_valid && (win_q != 8'h00) && (cnt > CNT_WIDTH'(win_q));
`else
  assign early_kick = 1'b0;
`endif

  assign kick_load = kick_valid && !early_kick;

  wdt_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .RST_VALUE (DEFAULT_TIMEOUT)
  ) u_counter (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .reload_on_rst_i (!en_q[1]),
    .force_zero_i    (early_kick),
    .load_i          (kick_load),
    .load_val_i      (tout_q),
    .dec_i           (ce && (en_q != 2'b00)),
    .preto_i         (preto_q),
    .cnt_o           (cnt),
    .zero_o          (bite),
    .pre_hit_o       (pre_hit)
  );

  // A kick landing on the first zero cycle reloads the count before the
  // bite is ever reported.
  assign bite_edge = bite && !prev_bite_q && !kick_load;

  // Configuration writes (blocked by LOCK)
  always_comb begin
    en_d    = en_q;
    oe_d    = oe_q;
    ptie_d  = ptie_q;
    lock_d  = lock_q;
    tout_d  = tout_q;
    preto_d = preto_q;
`ifdef WATCHDOG_WINDOW_EN
    win_d   = win_q;
`endif
    if (csr_we && !lock_q) begin
      case (off)
        R_CTRL: begin
          en_d   = csr_di[CTRL_EN_LSB +: 2];
          lock_d = csr_di[CTRL_LOCK];
          ptie_d = csr_di[CTRL_PTIE];
          oe_d   = csr_di[CTRL_OE_LSB +: 2];
        end
        R_TOUT_L: tout_d  = CNT_WIDTH'({tout16[15:8], csr_di});
        R_TOUT_H: tout_d  = CNT_WIDTH'({csr_di, tout16[7:0]});
        R_PRETO:  preto_d = csr_di;
`ifdef WATCHDOG_WINDOW_EN
        R_WIN:    win_d   = csr_di;
`endif
        default: ;
      endcase
    end
  end

  // Sticky status: a new event in the same cycle as its W1C wins.
  always_comb begin
    status_set           = 3'b000;
    status_set[ST_BITE]  = bite_edge;
    status_set[ST_PRE]   = pre_hit;
    status_set[ST_EARLY] = early_kick;
    status_clr           = (csr_we && (off == R_STATUS)) ? csr_di[2:0] : 3'b000;
    status_d             = (status_q & ~status_clr) | status_set;
    irq_d                = bite_edge || (pre_hit && ptie_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q        <= DEFAULT_EN;
      oe_q        <= DEFAULT_OE;
      ptie_q      <= 1'b0;
      lock_q      <= 1'b0;
      tout_q      <= DEFAULT_TIMEOUT;
      preto_q     <= 8'h00;
      status_q    <= 3'b000;
      irq_q       <= 1'b0;
      // Treat a count that survives reset at zero as already reported.
      prev_bite_q <= 1'b1;
    end else begin
      en_q        <= en_d;
      oe_q        <= oe_d;
      ptie_q      <= ptie_d;
      lock_q      <= lock_d;
      tout_q      <= tout_d;
      preto_q     <= preto_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
      prev_bite_q <= bite;
    end
  end

`ifdef WATCHDOG_WINDOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q <= 8'h00;
    end else begin
      win_q <= win_d;
    end
  end
`endif

  // Read mux
  always_comb begin
    csr_do = 8'h00;
    case (off)
      R_CTRL: begin
        csr_do[CTRL_EN_LSB +: 2] = en_q;
        csr_do[CTRL_LOCK]        = lock_q;
        csr_do[CTRL_PTIE]        = ptie_q;
        csr_do[CTRL_OE_LSB +: 2] = oe_q;
      end
      R_TOUT_L: csr_do = tout16[7:0];
      R_TOUT_H: csr_do = tout16[15:8];
      R_CNT_L:  csr_do = cnt16[7:0];
      R_CNT_H:  csr_do = cnt16[15:8];
      R_PRETO:  csr_do = preto_q;
      R_STATUS: csr_do = {5'b00000, status_q};
`ifdef WATCHDOG_WINDOW_EN
      R_WIN:    csr_do = win_q;
`endif
      default:  csr_do = 8'h00;
    endcase
  end

  assign wdt_out             = oe_q & {bite, bite};
  assign force_recovery_mode = en_q[1];
  assign irq                 = irq_q;

endmodule

// File: tb/tb_watchdog_v2.sv
// tb/tb_watchdog_v2.sv - self-checking bench for watchdog_v2 against a behavioural model

module tb_watchdog_v2;

  localparam int MASK = 12'hfff;
`ifdef WATCHDOG_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic       clk, rst_n, ce, csr_we;
  logic [4:0] csr_a;
  logic [7:0] csr_di, csr_do;
  logic [1:0] wdt_out;
  logic       force_recovery_mode, irq;

  watchdog_v2 dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ce                  (ce),
    .csr_a               (csr_a),
    .csr_di              (csr_di),
    .csr_we              (csr_we),
    .csr_do              (csr_do),
    .wdt_out             (wdt_out),
    .force_recovery_mode (force_recovery_mode),
    .irq                 (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  int         m_cnt, m_tout, m_preto, m_win, m_status;
  logic [1:0] m_en, m_oe;
  bit         m_ptie, m_lock, m_prev, m_irq;

  function automatic logic [7:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return {m_oe, 1'b0, m_ptie, 1'b0, m_lock, m_en};
      5'd1:    return 8'(m_tout & 255);
      5'd2:    return 8'(m_tout >> 8);
      5'd4:    return 8'(m_cnt & 255);
      5'd5:    return 8'(m_cnt >> 8);
      5'd6:    return 8'(m_preto);
      5'd7:    return 8'(m_status);
      5'd8:    return WIN_EN ? 8'(m_win) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_step(input bit rstn, input bit c, input bit we,
                        input logic [4:0] a, input logic [7:0] d);
    bit bite_now, kick, early, dec, pre, bite_ev;
    int nc;
    bite_now = (m_cnt == 0);
    if (!rstn) begin
      if (!m_en[1]) m_cnt = MASK;
      m_en = 2'b00; m_oe = 2'b00; m_ptie = 0; m_lock = 0;
      m_tout = MASK; m_preto = 0; m_win = 0; m_status = 0;
      m_irq = 0; m_prev = 1;
      return;
    end
    kick  = we && (a == 5'd3) && (d == 8'h6b);
    early = WIN_EN && kick && (m_win != 0) && (m_cnt > m_win);
    nc = m_cnt;
    dec = 0;
    if (early) nc = 0;
    else if (kick) nc = m_tout;
    else if (c && (m_en != 2'b00) && (m_cnt > 0)) begin
      nc = m_cnt - 1;
      dec = 1;
    end
    pre     = dec && (m_preto != 0) && (nc == m_preto) && (m_preto < m_tout);
    bite_ev = bite_now && !m_prev && !(kick && !early);
    m_irq   = bite_ev || (pre && m_ptie);
    if (we && (a == 5'd7)) m_status = m_status & (7 ^ int'(d[2:0]));
    m_status = m_status | int'(bite_ev) | (int'(pre) << 1) | (int'(early) << 2);
    if (we && !m_lock) begin
      case (a)
        5'd0: begin m_oe = d[7:6]; m_ptie = d[4]; m_lock = d[2]; m_en = d[1:0]; end
        5'd1: m_tout = (m_tout & 'hf00) | int'(d);
        5'd2: m_tout = ((int'(d) & 'h0f) << 8) | (m_tout & 'hff);
        5'd6: m_preto = int'(d);
        5'd8: if (WIN_EN) m_win = int'(d);
        default: ;
      endcase
    end
    m_prev = bite_now;
    m_cnt  = nc;
  endtask

  task automatic rd_chk(input logic [4:0] a);
    csr_a = a;
    #1;
    chk($sformatf("read_%0d", a), csr_do, m_read(a));
  endtask

  task automatic peek(input logic [4:0] a, output logic [7:0] v);
    csr_a = a;
    #1;
    v = csr_do;
  endtask

  // One clock: drive, advance model, then check outputs and a few reads.
  task automatic cyc(input bit rstn, input bit c, input bit we,
                     input logic [4:0] a, input logic [7:0] d);
    rst_n = rstn; ce = c; csr_we = we; csr_a = a; csr_di = d;
    m_step(rstn, c, we, a, d);
    @(posedge clk);
    #1;
    rst_n = 1'b1; ce = 1'b0; csr_we = 1'b0;
    chk("wdt_out", wdt_out, m_oe & {2{m_cnt == 0}});
    chk("irq", irq, m_irq);
    chk("frm", force_recovery_mode, m_en[1]);
    rd_chk(5'd4);
    rd_chk(5'd5);
    rd_chk(5'($urandom_range(0, 10)));
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1, 0, 1, a, d);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 5'd0, 8'h00);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 5'd0, 8'h00);
  endtask

  logic [7:0] v;

  initial begin
    rst_n = 1'b0; ce = 1'b0; csr_we = 1'b0; csr_a = 5'd0; csr_di = 8'h00;
    m_en = 2'b00; m_cnt = 0;
    m_step(0, 0, 0, 5'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Reset defaults
    peek(5'd0, v); chk("rst_ctrl", v, 8'h00);
    peek(5'd4, v); chk("rst_cnt_l", v, 8'hff);
    peek(5'd5, v); chk("rst_cnt_h", v, 8'h0f);
    chk("rst_wdt_out", wdt_out, 2'b00);
    chk("rst_irq", irq, 1'b0);

    // Basic bite
    wr(0, 8'hc1); wr(1, 8'h05); wr(2, 8'h00); wr(3, 8'h6b);
    tick(5);
    chk("bite_wdt_out", wdt_out, 2'b11);
    idle();
    chk("bite_irq", irq, 1'b1);
    peek(5'd7, v); chk("bite_status", v, 8'h01);
    idle();
    chk("bite_irq_one_cycle", irq, 1'b0);
    wr(7, 8'h01);

    // Pretimeout then bite
    wr(0, 8'hd1); wr(6, 8'h03); wr(1, 8'h0a); wr(3, 8'h6b);
    tick(7);
    chk("pre_irq", irq, 1'b1);
    peek(5'd4, v); chk("pre_cnt", v, 8'h03);
    peek(5'd7, v); chk("pre_status", v, 8'h02);
    tick(3);
    idle();
    chk("pre_bite_irq", irq, 1'b1);
    peek(5'd7, v); chk("pre_bite_status", v, 8'h03);
    wr(7, 8'h03);

    // Bad kick byte, kick on the bite edge
    wr(6, 8'h00); wr(0, 8'hc1); wr(3, 8'h6b); wr(3, 8'h6a);
    peek(5'd4, v); chk("bad_kick_cnt", v, 8'h0a);
    tick(10);
    wr(3, 8'h6b);
    peek(5'd4, v); chk("edge_kick_cnt", v, 8'h0a);
    idle();
    chk("edge_kick_irq", irq, 1'b0);
    peek(5'd7, v); chk("edge_kick_status", v, 8'h00);

    // Lock and failsafe reset
    wr(0, 8'hc5); wr(1, 8'h33); wr(0, 8'h02);
    peek(5'd1, v); chk("lock_tout", v, 8'h0a);
    peek(5'd0, v); chk("lock_ctrl", v, 8'hc5);
    cyc(0, 0, 0, 5'd0, 8'h00);
    peek(5'd0, v); chk("unlock_ctrl", v, 8'h00);
    wr(0, 8'h02);
    chk("frm_set", force_recovery_mode, 1'b1);
    wr(3, 8'h6b); tick(3);
    cyc(0, 0, 0, 5'd0, 8'h00);
    peek(5'd4, v); chk("failsafe_cnt_l", v, 8'hfc);
    peek(5'd5, v); chk("failsafe_cnt_h", v, 8'h0f);

    // Window mode
    cyc(0, 0, 0, 5'd0, 8'h00);
    wr(0, 8'hc1); wr(8, 8'h04); wr(1, 8'h14); wr(2, 8'h00); wr(3, 8'h6b);
    tick(10);
    wr(3, 8'h6b);
    if (WIN_EN) begin
      peek(5'd4, v); chk("early_cnt", v, 8'h00);
      idle();
      chk("early_irq", irq, 1'b1);
      peek(5'd7, v); chk("early_status", v, 8'h05);
      wr(7, 8'h07); wr(3, 8'h6b); tick(16); wr(3, 8'h6b);
      peek(5'd4, v); chk("window_kick_cnt", v, 8'h14);
    end else begin
      peek(5'd8, v); chk("win_absent", v, 8'h00);
      peek(5'd4, v); chk("no_window_kick_cnt", v, 8'h14);
    end

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic [4:0] a;
      logic [7:0] d;
      bit we, rs;
      rs = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 9) < 3);
      a  = ($urandom_range(0, 19) == 0) ? 5'd12 : 5'($urandom_range(0, 8));
      d  = 8'($urandom);
      if (a == 5'd3 && $urandom_range(0, 9) < 7) d = 8'h6b;
      if (a == 5'd2 && $urandom_range(0, 4) != 0) d = 8'h00;
      if (a == 5'd0 && $urandom_range(0, 15) != 0) d[2] = 1'b0;
      cyc(rs, ($urandom_range(0, 9) < 6), we, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
